// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the pipeline debug controller: UART command bytes,
// debug frame layout constants, the controller state encoding and the default
// opcode that marks the end of a program.
package debug_pkg;

    // Command bytes received from the UART receiver
    localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_PAUSE = 8'h68;  // 'h'
    localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'

    // Frame layout: header byte followed by FRAME_WORDS words, MSB byte first
    localparam logic [7:0]  FRAME_HDR   = 8'hA5;
    localparam int unsigned FRAME_WORDS = 5;
    localparam int unsigned FRAME_BYTES = 21;

    localparam logic [5:0] HALT_OP_DEFAULT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SEND,
        ST_DONE
    } dbg_state_t;

endpackage

// File: rtl/debug_frame_tx.sv
// debug_frame_tx
// Captures a five-word pipeline snapshot on `start` and serialises it as a
// debug frame (header, then each word MSB byte first) over a valid/ready
// byte handshake.
// Ports:
//   clk, reset         - clock, synchronous active-low reset
//   start              - one-cycle pulse: capture words and begin a frame
//   w_cycle .. w_wb    - snapshot words, in frame order
//   tx_data, tx_valid  - registered byte stream towards the UART transmitter
//   tx_ready           - transmitter accepts the current byte
//   done               - pulse in the cycle the last byte is accepted
module debug_frame_tx
    import debug_pkg::*;
#(
    parameter int unsigned B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [B-1:0] w_cycle,
    input  logic [B-1:0] w_pc,
    input  logic [B-1:0] w_instr,
    input  logic [B-1:0] w_alu,
    input  logic [B-1:0] w_wb,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         done
);

    localparam int unsigned SNAP_W = FRAME_WORDS * B;

    // Snapshot is held as one vector and consumed from the top, so the byte
    // for the next transfer is always the upper byte.
    logic [SNAP_W-1:0] snap;
    logic [4:0]        idx;
    logic              xfer;
    logic              last;

    assign xfer = tx_valid & tx_ready;
    assign last = (idx == 5'(FRAME_BYTES - 1));
    assign done = xfer & last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            snap     <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (start) begin
            snap     <= {w_cycle, w_pc, w_instr, w_alu, w_wb};
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= FRAME_HDR;
        end else if (xfer) begin
            if (last) begin
                idx      <= '0;
                tx_valid <= 1'b0;
                tx_data  <= '0;
            end else begin
                idx      <= idx + 5'd1;
                tx_data  <= snap[SNAP_W-1 -: 8];
                snap     <= snap << 8;
            end
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl
// Run/step/halt controller for the 5-stage pipeline. Decodes single-byte UART
// commands, drives the global pipeline advance enable, counts enabled cycles,
// detects the HALT opcode in IF/ID and sends a snapshot frame on halt, pause,
// step completion or dump request.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   rx_data, rx_valid     - command byte from the UART receiver
//   tx_data, tx_valid,
//   tx_ready              - frame byte handshake to the UART transmitter
//   pc_if, instr_ifid,
//   alu_exmem, wb_data    - pipeline state captured into the snapshot
//   pipe_en               - pipeline advance enable (combinational)
//   halted                - program reached HALT_OP (sticky until reset)
//   busy                  - frame transmission in progress
module pipeline_debug_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned B       = 32,
    parameter logic [5:0]  HALT_OP = HALT_OP_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [B-1:0] pc_if,
    input  logic [B-1:0] instr_ifid,
    input  logic [B-1:0] alu_exmem,
    input  logic [B-1:0] wb_data,
    output logic         pipe_en,
    output logic         halted,
    output logic         busy
);

    dbg_state_t  state;
    logic [31:0] cycle_cnt;
    logic        halt_det;
    logic        frame_done;
    logic        cmd_run;
    logic        cmd_step;
    logic        cmd_pause;
    logic        cmd_dump;

    assign cmd_run   = rx_valid && (rx_data == CMD_RUN);
    assign cmd_step  = rx_valid && (rx_data == CMD_STEP);
    assign cmd_pause = rx_valid && (rx_data == CMD_PAUSE);
    assign cmd_dump  = rx_valid && (rx_data == CMD_DUMP);

    assign halt_det = (instr_ifid[B-1 -: 6] == HALT_OP);

    // Halt gates the enable in the same cycle so the HALT instruction stays
    // in IF/ID and lands in the snapshot.
    assign pipe_en = (state == ST_STEP) || ((state == ST_RUN) && !halt_det);
    assign busy    = (state == ST_SEND);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (pipe_en && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (cmd_run)
                        state <= ST_RUN;
                    else if (cmd_step)
                        state <= ST_STEP;
                    else if (cmd_dump)
                        state <= ST_SNAP;
                end
                ST_RUN: begin
                    // Halt outranks a simultaneous pause.
                    if (halt_det) begin
                        state  <= ST_SNAP;
                        halted <= 1'b1;
                    end else if (cmd_pause) begin
                        state <= ST_SNAP;
                    end
                end
                ST_STEP: state <= ST_SNAP;
                ST_SNAP: state <= ST_SEND;
                ST_SEND: begin
                    if (frame_done)
                        state <= halted ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    if (cmd_dump)
                        state <= ST_SNAP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    debug_frame_tx #(
        .B (B)
    ) u_frame_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (state == ST_SNAP),
        .w_cycle  (B'(cycle_cnt)),
        .w_pc     (pc_if),
        .w_instr  (instr_ifid),
        .w_alu    (alu_exmem),
        .w_wb     (wb_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (frame_done)
    );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb_pipeline_debug_ctrl
// Directed self-checking bench for pipeline_debug_ctrl: reset values, dump,
// single step, run to halt, back-pressure, halt/pause priority, pause and
// resume, and reset in the middle of a frame.
module tb_pipeline_debug_ctrl;

    localparam logic [31:0] PC_V   = 32'h0040_0004;
    localparam logic [31:0] INS_V  = 32'h8C22_0008;
    localparam logic [31:0] ALU_V  = 32'h1001_0000;
    localparam logic [31:0] WB_V   = 32'hDEAD_BEEF;
    localparam logic [31:0] HALT_V = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] pc_if;
    logic [31:0] instr_ifid;
    logic [31:0] alu_exmem;
    logic [31:0] wb_data;
    logic        pipe_en;
    logic        halted;
    logic        busy;

    pipeline_debug_ctrl #(
        .B       (32),
        .HALT_OP (6'h3F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .pc_if      (pc_if),
        .instr_ifid (instr_ifid),
        .alu_exmem  (alu_exmem),
        .wb_data    (wb_data),
        .pipe_en    (pipe_en),
        .halted     (halted),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] cap [0:20];
    logic [7:0] ref_frame [0:20];
    int         cap_n;
    int         pen_cnt;
    int         first_valid;
    int         stall_cnt;
    int         stall_viol;

    // Expected frame byte k for the fixed pc/alu/wb inputs
    function automatic logic [7:0] exp_byte(int k, logic [31:0] c, logic [31:0] i);
        logic [31:0] wd;
        int          b;
        if (k == 0) return 8'hA5;
        case ((k - 1) / 4)
            0:       wd = c;
            1:       wd = PC_V;
            2:       wd = i;
            3:       wd = ALU_V;
            default: wd = WB_V;
        endcase
        b  = 3 - ((k - 1) % 4);
        wd = wd >> (8 * b);
        return wd[7:0];
    endfunction

    // Index of first byte differing from the expected frame, 99 if the frame
    // is incomplete, -1 if identical
    function automatic int frame_mismatch(logic [31:0] c, logic [31:0] i);
        if (cap_n != 21) return 99;
        for (int k = 0; k < 21; k++)
            if (cap[k] !== exp_byte(k, c, i)) return k;
        return -1;
    endfunction

    task automatic send_cmd(input logic [7:0] c);
        rx_data  = c;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Collects transferred bytes until stop_after transfers or a cycle budget
    task automatic capture(input bit gated, input int stop_after);
        bit         fin;
        bit         prev_stall;
        logic [7:0] prev_data;
        fin = 0; prev_stall = 0; prev_data = '0;
        cap_n = 0; pen_cnt = 0; first_valid = -1; stall_cnt = 0; stall_viol = 0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            tx_ready = gated ? (((cyc / 3) % 2) == 1) : 1'b1;
            #1;
            if (pipe_en) pen_cnt++;
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (prev_stall) stall_cnt++;
            if (tx_valid && tx_ready) begin
                cap[cap_n] = tx_data;
                cap_n++;
                if (cap_n == stop_after) fin = 1;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (pipe_en !== 1'b0) begin fails++; $display("FAIL reset_pipe_en: got %b expected 0", pipe_en); end
        tests_run++;
        if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        tests_run++;
        if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        tests_run++;
        if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dump();
        int m;
        send_cmd(8'h64);
        capture(0, 21);
        m = frame_mismatch(32'd0, INS_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL dump_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd0, INS_V), cap_n);
        end
        tests_run++;
        if (first_valid != 1) begin fails++; $display("FAIL dump_latency: got %0d expected 1", first_valid); end
        tests_run++;
        if (pen_cnt != 0) begin fails++; $display("FAIL dump_pipe_en: got %0d enabled cycles expected 0", pen_cnt); end
        tests_run++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            fails++; $display("FAIL dump_idle: got busy=%b tx_valid=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_step();
        int m;
        for (int s = 1; s <= 3; s++) begin
            send_cmd(8'h73);
            capture(0, 21);
            tests_run++;
            if (pen_cnt != 1) begin fails++; $display("FAIL step%0d_pipe_en: got %0d enabled cycles expected 1", s, pen_cnt); end
            tests_run++;
            if (first_valid != 2) begin fails++; $display("FAIL step%0d_latency: got %0d expected 2", s, first_valid); end
            m = frame_mismatch(32'(s), INS_V);
            tests_run++;
            if (m != -1) begin
                fails++;
                $display("FAIL step%0d_frame: byte %0d got %02h expected %02h (captured %0d of 21)", s, m,
                         (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'(s), INS_V), cap_n);
            end
        end
    endtask

    task automatic test_run_halt();
        int m;
        int cnt;
        instr_ifid = INS_V;
        pulse_reset();
        send_cmd(8'h63);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1; if (pipe_en) cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (cnt != 10) begin fails++; $display("FAIL run_enabled: got %0d expected 10", cnt); end
        instr_ifid = HALT_V;
        #1;
        tests_run++;
        if (pipe_en !== 1'b0) begin fails++; $display("FAIL run_halt_gate: got pipe_en=%b expected 0", pipe_en); end
        @(negedge clk);
        tests_run++;
        if (halted !== 1'b1) begin fails++; $display("FAIL run_halted_in_snap: got %b expected 1", halted); end
        capture(0, 21);
        m = frame_mismatch(32'd10, HALT_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL halt_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd10, HALT_V), cap_n);
        end
        send_cmd(8'h63);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1; if (pipe_en) cnt++;
            @(negedge clk);
        end
        send_cmd(8'h73);
        for (int k = 0; k < 4; k++) begin
            #1; if (pipe_en || tx_valid) cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (cnt != 0) begin fails++; $display("FAIL done_ignores_cmds: got %0d active cycles expected 0", cnt); end
        tests_run++;
        if (halted !== 1'b1) begin fails++; $display("FAIL done_halted: got %b expected 1", halted); end
    endtask

    task automatic test_back_to_back_backpressure();
        int m;
        int diff;
        instr_ifid = INS_V;
        pulse_reset();
        send_cmd(8'h64);
        capture(0, 21);
        for (int k = 0; k < 21; k++) ref_frame[k] = cap[k];
        m = frame_mismatch(32'd0, INS_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL bp_ref_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd0, INS_V), cap_n);
        end
        send_cmd(8'h64);
        capture(1, 21);
        diff = 0;
        for (int k = 0; k < 21; k++) if (cap[k] !== ref_frame[k]) diff++;
        tests_run++;
        if (cap_n != 21 || diff != 0) begin
            fails++; $display("FAIL bp_sequence: got %0d bytes with %0d differing, expected 21 with 0", cap_n, diff);
        end
        tests_run++;
        if (stall_cnt == 0 || stall_viol != 0) begin
            fails++; $display("FAIL bp_stable: got %0d unstable stalls over %0d stalls, expected 0 over >0", stall_viol, stall_cnt);
        end
    endtask

    task automatic test_halt_priority();
        int m;
        instr_ifid = INS_V;
        pulse_reset();
        send_cmd(8'h63);
        for (int k = 0; k < 5; k++) @(negedge clk);
        instr_ifid = HALT_V;
        rx_data    = 8'h68;
        rx_valid   = 1'b1;
        #1;
        tests_run++;
        if (pipe_en !== 1'b0) begin fails++; $display("FAIL prio_gate: got pipe_en=%b expected 0", pipe_en); end
        @(negedge clk);
        rx_valid = 1'b0;
        capture(0, 21);
        m = frame_mismatch(32'd5, HALT_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL prio_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd5, HALT_V), cap_n);
        end
        tests_run++;
        if (halted !== 1'b1) begin fails++; $display("FAIL prio_halted: got %b expected 1", halted); end
    endtask

    task automatic test_pause_resume();
        int m;
        instr_ifid = INS_V;
        pulse_reset();
        send_cmd(8'h63);
        for (int k = 0; k < 4; k++) @(negedge clk);
        send_cmd(8'h68);
        capture(0, 21);
        m = frame_mismatch(32'd5, INS_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL pause_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd5, INS_V), cap_n);
        end
        tests_run++;
        if (halted !== 1'b0 || pipe_en !== 1'b0) begin
            fails++; $display("FAIL pause_idle: got halted=%b pipe_en=%b expected 0 0", halted, pipe_en);
        end
        send_cmd(8'h63);
        for (int k = 0; k < 2; k++) @(negedge clk);
        send_cmd(8'h68);
        capture(0, 21);
        m = frame_mismatch(32'd8, INS_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL resume_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd8, INS_V), cap_n);
        end
    endtask

    task automatic test_reset_midframe();
        int m;
        int vcnt;
        instr_ifid = INS_V;
        pulse_reset();
        send_cmd(8'h63);
        for (int k = 0; k < 2; k++) @(negedge clk);
        instr_ifid = HALT_V;
        capture(0, 7);
        tests_run++;
        if (tx_valid !== 1'b1 || halted !== 1'b1 || cap_n != 7) begin
            fails++; $display("FAIL mid_precond: got tx_valid=%b halted=%b bytes=%0d expected 1 1 7", tx_valid, halted, cap_n);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            fails++; $display("FAIL mid_abort: got tx_valid=%b tx_data=%02h expected 0 00", tx_valid, tx_data);
        end
        tests_run++;
        if (halted !== 1'b0 || busy !== 1'b0 || pipe_en !== 1'b0) begin
            fails++; $display("FAIL mid_flags: got halted=%b busy=%b pipe_en=%b expected 0 0 0", halted, busy, pipe_en);
        end
        reset      = 1'b1;
        instr_ifid = INS_V;
        tx_ready   = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (tx_valid) vcnt++;
        end
        tx_ready = 1'b0;
        tests_run++;
        if (vcnt != 0) begin fails++; $display("FAIL mid_no_resume: got %0d valid cycles expected 0", vcnt); end
        send_cmd(8'h64);
        capture(0, 21);
        m = frame_mismatch(32'd0, INS_V);
        tests_run++;
        if (m != -1) begin
            fails++;
            $display("FAIL mid_post_frame: byte %0d got %02h expected %02h (captured %0d of 21)", m,
                     (m >= 0 && m < 21) ? cap[m] : 8'h00, exp_byte(m, 32'd0, INS_V), cap_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b0;
        pc_if      = PC_V;
        instr_ifid = INS_V;
        alu_exmem  = ALU_V;
        wb_data    = WB_V;

        test_reset();
        test_dump();
        test_step();
        test_run_halt();
        test_back_to_back_backpressure();
        test_halt_priority();
        test_pause_resume();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
